// File: rtl/sprite_cmd_encoder_pkg.sv
// Shared types and constants for the sprite command encoder: command word
// layout, request record, FSM state encoding and word-building helpers.
package sprite_cmd_pkg;

    localparam int SUB_COMP_W = 6;
    localparam int CHILD_W    = 5;
    localparam int INFO_W     = 4;
    localparam int TYPE_W     = 3;
    localparam int MSG_W      = 13;
    localparam int MASK_W     = 4;
    localparam int PATTERN_W  = 5;
    localparam int COORD_W    = 10;

    localparam int MSG_VISIBLE_BIT = 12;
    localparam int MSG_FLIP_BIT    = 11;

    localparam logic [INFO_W-1:0] INFO_WRITE = 4'b0001;
    localparam logic [INFO_W-1:0] INFO_FLUSH = 4'b1111;

    localparam logic [TYPE_W-1:0] TYPE_NONE  = 3'b000;
    localparam logic [TYPE_W-1:0] TYPE_ATTR  = 3'b001;
    localparam logic [TYPE_W-1:0] TYPE_X     = 3'b010;
    localparam logic [TYPE_W-1:0] TYPE_Y     = 3'b011;
    localparam logic [TYPE_W-1:0] TYPE_SHIFT = 3'b100;

    typedef enum logic [2:0] {
        S_IDLE,
        S_POP,
        S_EMIT,
        S_GAP,
        S_FLUSH,
        S_FGAP
    } enc_state_t;

    typedef struct packed {
        logic [SUB_COMP_W-1:0] sub_comp;
        logic [CHILD_W-1:0]    child;
        logic [INFO_W-1:0]     info;
        logic [TYPE_W-1:0]     typ;
        logic                  pp_selc;
        logic [MSG_W-1:0]      msg;
    } cmd_word_t;

    typedef struct packed {
        logic [SUB_COMP_W-1:0] sub_comp;
        logic [CHILD_W-1:0]    child;
        logic [MASK_W-1:0]     mask;
        logic                  visible;
        logic                  flip;
        logic [PATTERN_W-1:0]  pattern;
        logic [COORD_W-1:0]    x;
        logic [COORD_W-1:0]    y;
        logic [COORD_W-1:0]    shift;
    } cmd_req_t;

    localparam int REQ_W = $bits(cmd_req_t);

    // Mask bit 0 is serviced first, bit 3 last.
    function automatic logic [1:0] lowest_field(input logic [MASK_W-1:0] mask);
        logic [1:0] f;
        if (mask[0])      f = 2'd0;
        else if (mask[1]) f = 2'd1;
        else if (mask[2]) f = 2'd2;
        else              f = 2'd3;
        return f;
    endfunction

    function automatic cmd_word_t field_word(input cmd_req_t r, input logic [1:0] f,
                                             input logic pp);
        cmd_word_t w;
        w          = '0;
        w.sub_comp = r.sub_comp;
        w.child    = r.child;
        w.info     = INFO_WRITE;
        w.pp_selc  = pp;
        case (f)
            2'd0: begin
                w.typ                      = TYPE_ATTR;
                w.msg[MSG_VISIBLE_BIT]     = r.visible;
                w.msg[MSG_FLIP_BIT]        = r.flip;
                w.msg[PATTERN_W-1:0]       = r.pattern;
            end
            2'd1: begin
                w.typ                = TYPE_X;
                w.msg[COORD_W-1:0]   = r.x;
            end
            2'd2: begin
                w.typ                = TYPE_Y;
                w.msg[COORD_W-1:0]   = r.y;
            end
            default: begin
                w.typ                = TYPE_SHIFT;
                w.msg[COORD_W-1:0]   = r.shift;
            end
        endcase
        return w;
    endfunction

    function automatic cmd_word_t flush_word(input logic [SUB_COMP_W-1:0] sub,
                                             input logic pp);
        cmd_word_t w;
        w          = '0;
        w.sub_comp = sub;
        w.info     = INFO_FLUSH;
        w.typ      = TYPE_NONE;
        w.pp_selc  = pp;
        return w;
    endfunction

endpackage

// File: rtl/sprite_cmd_encoder_if.sv
// Request/command bus of the sprite command encoder. The master side is the
// game logic plus the display fan-out; the slave side is the encoder.
// Optional macro CMD_WORD_COUNT_EN adds words_last_frame.
interface sprite_cmd_encoder_if;
    logic        req_valid;
    logic        req_ready;
    logic [5:0]  req_sub_comp;
    logic [4:0]  req_child;
    logic [3:0]  req_mask;
    logic        req_visible;
    logic        req_flip;
    logic [4:0]  req_pattern;
    logic [9:0]  req_x;
    logic [9:0]  req_y;
    logic [9:0]  req_shift;
    logic        frame_end;
    logic [31:0] writedata;
    logic        back_buf;
    logic        flush_overrun;
`ifdef CMD_WORD_COUNT_EN
    logic [15:0] words_last_frame;
`endif

    modport master (
        output req_valid, req_sub_comp, req_child, req_mask, req_visible, req_flip,
               req_pattern, req_x, req_y, req_shift, frame_end,
        input  req_ready, writedata, back_buf, flush_overrun
`ifdef CMD_WORD_COUNT_EN
        , input words_last_frame
`endif
    );

    modport slave (
        input  req_valid, req_sub_comp, req_child, req_mask, req_visible, req_flip,
               req_pattern, req_x, req_y, req_shift, frame_end,
        output req_ready, writedata, back_buf, flush_overrun
`ifdef CMD_WORD_COUNT_EN
        , output words_last_frame
`endif
    );
endinterface

// File: rtl/sprite_cmd_encoder_fifo.sv
// Synchronous request FIFO. DEPTH must be a power of two so the pointers wrap
// naturally; writes while full and reads while empty are ignored.
module cmd_req_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q, count_d;
    logic             push_ok, pop_ok;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign rdata_o = mem[rd_ptr_q];

    // Occupancy follows accepted pushes and pops.
    always_comb begin
        count_d = count_q;
        if (push_ok && !pop_ok)      count_d = count_q + 1'b1;
        else if (!push_ok && pop_ok) count_d = count_q - 1'b1;
    end

    // Storage array carries no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_q] <= wdata_i;
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end
endmodule

// File: rtl/sprite_cmd_encoder.sv
// Sprite command encoder: turns queued object updates into one-cycle command
// words separated by idle words, and inserts one buffer-swap flush per frame.
// Optional macro CMD_WORD_COUNT_EN adds the words_last_frame statistic.
//
// state   | meaning
// S_IDLE  | waiting; pending flush beats queued requests
// S_POP   | latch FIFO head into the working register
// S_EMIT  | drive word for lowest remaining field
// S_GAP   | idle word between fields
// S_FLUSH | drive flush word
// S_FGAP  | idle word, swap back buffer
module sprite_cmd_encoder
    import sprite_cmd_pkg::*;
#(
    parameter int                    FIFO_DEPTH     = 8,
    parameter logic [SUB_COMP_W-1:0] FLUSH_SUB_COMP = 6'd0
) (
    input logic                 clk,
    input logic                 reset,
    sprite_cmd_encoder_if.slave bus
);
    enc_state_t state_q, state_d;
    cmd_req_t   work_q, work_d;
    cmd_req_t   req_in, head;
    cmd_word_t  wdata;
    logic       back_buf_q, back_buf_d;
    logic       pending_q, pending_d;
    logic       overrun_q, overrun_d;
    logic       fifo_full, fifo_empty, fifo_pop;
    logic [1:0] cur_field;

    assign req_in = '{sub_comp: bus.req_sub_comp, child: bus.req_child, mask: bus.req_mask,
                      visible: bus.req_visible, flip: bus.req_flip, pattern: bus.req_pattern,
                      x: bus.req_x, y: bus.req_y, shift: bus.req_shift};

    cmd_req_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(REQ_W)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (bus.req_valid),
        .wdata_i (req_in),
        .pop_i   (fifo_pop),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign cur_field         = lowest_field(work_q.mask);
    assign bus.req_ready     = !fifo_full;
    assign bus.writedata     = wdata;
    assign bus.back_buf      = back_buf_q;
    assign bus.flush_overrun = overrun_q;

    // Next-state, word output and flush bookkeeping.
    always_comb begin
        state_d    = state_q;
        work_d     = work_q;
        back_buf_d = back_buf_q;
        pending_d  = pending_q;
        overrun_d  = overrun_q;
        wdata      = '0;
        fifo_pop   = 1'b0;

        // A strobe landing while the flush is being driven is a fresh request.
        if (bus.frame_end && pending_q && state_q != S_FLUSH) overrun_d = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (pending_q)        state_d = S_FLUSH;
                else if (!fifo_empty) state_d = S_POP;
            end
            S_POP: begin
                fifo_pop = 1'b1;
                work_d   = head;
                state_d  = (head.mask == '0) ? S_IDLE : S_EMIT;
            end
            S_EMIT: begin
                wdata                  = field_word(work_q, cur_field, back_buf_q);
                work_d.mask[cur_field] = 1'b0;
                state_d                = S_GAP;
            end
            S_GAP: begin
                state_d = (work_q.mask != '0) ? S_EMIT : S_IDLE;
            end
            S_FLUSH: begin
                wdata     = flush_word(FLUSH_SUB_COMP, back_buf_q);
                pending_d = 1'b0;
                state_d   = S_FGAP;
            end
            S_FGAP: begin
                back_buf_d = !back_buf_q;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (bus.frame_end) pending_d = 1'b1;
    end

    // State and bookkeeping registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            work_q     <= '0;
            back_buf_q <= 1'b1;
            pending_q  <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            work_q     <= work_d;
            back_buf_q <= back_buf_d;
            pending_q  <= pending_d;
            overrun_q  <= overrun_d;
        end
    end

`ifdef CMD_WORD_COUNT_EN
    logic [15:0] word_cnt_q, word_cnt_d;
    logic [15:0] words_last_q, words_last_d;

    // Count normal words per frame; snapshot and restart at each flush.
    always_comb begin
        word_cnt_d   = word_cnt_q;
        words_last_d = words_last_q;
        if (state_q == S_FLUSH) begin
            words_last_d = word_cnt_q;
            word_cnt_d   = '0;
        end else if (state_q == S_EMIT && word_cnt_q != 16'hFFFF) begin
            word_cnt_d = word_cnt_q + 16'd1;
        end
    end

    // Word counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_cnt_q   <= '0;
            words_last_q <= '0;
        end else begin
            word_cnt_q   <= word_cnt_d;
            words_last_q <= words_last_d;
        end
    end

    assign bus.words_last_frame = words_last_q;
`endif
endmodule

// File: tb/tb_sprite_cmd_encoder.sv
module tb_sprite_cmd_encoder;

    typedef struct {
        logic [5:0] sub;
        logic [4:0] child;
        logic [3:0] mask;
        logic       vis;
        logic       flip;
        logic [4:0] pat;
        logic [9:0] x;
        logic [9:0] y;
        logic [9:0] sh;
    } treq_t;

    typedef struct {
        treq_t       r;
        int          nw;
        logic [31:0] w [4];
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    sprite_cmd_encoder_if bus();

    sprite_cmd_encoder #(.FIFO_DEPTH(8), .FLUSH_SUB_COMP(6'd0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int          checks = 0;
    int          failures = 0;
    logic [31:0] exp_q [$];
    int          objn_q [$];
    int          obj_left = 0;
    bit          mon_en = 1'b0;
    bit          model_buf = 1'b1;
    int          flush_seen = 0;
    logic [31:0] prev_w = 32'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] field_msg(input treq_t r, input int i);
        logic [31:0] m;
        case (i)
            0:       m = (32'(r.vis) << 12) | (32'(r.flip) << 11) | 32'(r.pat);
            1:       m = 32'(r.x);
            2:       m = 32'(r.y);
            default: m = 32'(r.sh);
        endcase
        return m;
    endfunction

    function automatic logic [31:0] mk_word(input logic [5:0] sub, input logic [4:0] child,
                                            input logic [2:0] typ, input logic pp,
                                            input logic [31:0] msg);
        return (32'(sub) << 26) | (32'(child) << 21) | (32'd1 << 17) |
               (32'(typ) << 14) | (32'(pp) << 13) | msg;
    endfunction

    function automatic logic [31:0] flush_w(input logic pp);
        return 32'h001E0000 | (pp ? 32'h00002000 : 32'h0);
    endfunction

    function automatic vec_t make_vec(input treq_t r, input logic pp);
        vec_t v;
        v.r  = r;
        v.nw = 0;
        for (int i = 0; i < 4; i++) v.w[i] = 32'h0;
        for (int i = 0; i < 4; i++) begin
            if (r.mask[i]) begin
                v.w[v.nw] = mk_word(r.sub, r.child, 3'(i + 1), pp, field_msg(r, i));
                v.nw++;
            end
        end
        return v;
    endfunction

    function automatic treq_t rand_req();
        treq_t r;
        r.sub   = 6'($urandom);
        r.child = 5'($urandom);
        r.mask  = 4'($urandom);
        r.vis   = 1'($urandom);
        r.flip  = 1'($urandom);
        r.pat   = 5'($urandom);
        r.x     = 10'($urandom);
        r.y     = 10'($urandom);
        r.sh    = 10'($urandom);
        return r;
    endfunction

    task automatic set_req(input treq_t r, input logic v);
        bus.req_valid    = v;
        bus.req_sub_comp = r.sub;
        bus.req_child    = r.child;
        bus.req_mask     = r.mask;
        bus.req_visible  = r.vis;
        bus.req_flip     = r.flip;
        bus.req_pattern  = r.pat;
        bus.req_x        = r.x;
        bus.req_y        = r.y;
        bus.req_shift    = r.sh;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input treq_t r);
        vec_t v;
        v = make_vec(r, 1'b0);
        for (int i = 0; i < v.nw; i++) exp_q.push_back(v.w[i]);
        if (v.nw > 0) objn_q.push_back(v.nw);
    endtask

    task automatic apply_reset();
        bus.req_valid = 1'b0;
        bus.frame_end = 1'b0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int len;
        logic [31:0] e;
        len = (v.nw * 2 + 3 > 6) ? v.nw * 2 + 3 : 6;
        set_req(v.r, 1'b1);
        tick();
        bus.req_valid = 1'b0;
        for (int k = 1; k <= len; k++) begin
            e = 32'h0;
            if (k >= 3 && ((k - 3) % 2) == 0 && ((k - 3) / 2) < v.nw) e = v.w[(k - 3) / 2];
            check($sformatf("vec%0d_cyc%0d", idx, k), bus.writedata, e);
            tick();
        end
    endtask

    task automatic drain(input int budget);
        for (int k = 0; k < budget && exp_q.size() != 0; k++) tick();
        for (int k = 0; k < 20; k++) tick();
        check("drain_left", 32'(exp_q.size()), 32'd0);
    endtask

    // Stream monitor: order, buffer tagging, idle separation, no split objects.
    initial begin
        logic [31:0] w;
        forever begin
            @(posedge clk);
            #1;
            if (mon_en) begin
                w = bus.writedata;
                if (w != 32'h0) begin
                    checks++;
                    if (prev_w != 32'h0) begin
                        failures++;
                        $display("FAIL idle_gap actual=%h after=%h required=idle_between", w, prev_w);
                    end
                    if (w[20:17] == 4'hF) begin
                        check("flush_word", w, flush_w(model_buf));
                        check("flush_split", 32'(obj_left), 32'd0);
                        model_buf = ~model_buf;
                        flush_seen++;
                    end else begin
                        if (obj_left == 0 && objn_q.size() > 0) obj_left = objn_q.pop_front();
                        if (exp_q.size() == 0) begin
                            checks++;
                            failures++;
                            $display("FAIL unexpected_word actual=%h required=none", w);
                        end else begin
                            check("stream_word", w,
                                  exp_q.pop_front() | (model_buf ? 32'h2000 : 32'h0));
                        end
                        if (obj_left > 0) obj_left--;
                    end
                end
                prev_w = w;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t  tbl [10];
        treq_t r;
        treq_t plan;
        int    n_acc;
        int    nz;
        int    pulses;
        int    last_fe;
        bit    saw_low;
        logic [3:0] masks [10];
        vec_t  v4;

        masks[0] = 4'b0011; masks[1] = 4'b0001; masks[2] = 4'b0010; masks[3] = 4'b0100;
        masks[4] = 4'b1000; masks[5] = 4'b0101; masks[6] = 4'b1010; masks[7] = 4'b1111;
        masks[8] = 4'b0000; masks[9] = 4'b1001;

        plan.sub = 6'd15; plan.child = 5'd0; plan.mask = 4'b0011; plan.vis = 1'b1;
        plan.flip = 1'b0; plan.pat = 5'd0; plan.x = 10'd100; plan.y = 10'd0; plan.sh = 10'd0;

        tbl[0].r  = plan;
        tbl[0].nw = 2;
        tbl[0].w[0] = 32'h3C027000;
        tbl[0].w[1] = 32'h3C02A064;
        tbl[0].w[2] = 32'h0;
        tbl[0].w[3] = 32'h0;
        for (int i = 1; i < 10; i++) begin
            r = rand_req();
            r.mask = masks[i];
            tbl[i] = make_vec(r, 1'b1);
        end

        set_req(plan, 1'b0);
        bus.frame_end = 1'b0;
        reset = 1'b1;
        tick();
        tick();
        check("rst_writedata", bus.writedata, 32'h0);
        check("rst_back_buf", 32'(bus.back_buf), 32'd1);
        check("rst_overrun", 32'(bus.flush_overrun), 32'd0);
        check("rst_ready", 32'(bus.req_ready), 32'd1);
        reset = 1'b0;
        tick();

        // Single object: latency and field order.
        set_req(plan, 1'b1);
        tick();
        bus.req_valid = 1'b0;
        check("plan_t1", bus.writedata, 32'h0);
        tick();
        check("plan_t2", bus.writedata, 32'h0);
        tick();
        check("plan_attr", bus.writedata, 32'h3C027000);
        tick();
        check("plan_gap", bus.writedata, 32'h0);
        tick();
        check("plan_x", bus.writedata, 32'h3C02A064);
        tick();
        check("plan_after", bus.writedata, 32'h0);
        tick();

        // Two flushes while idle.
        for (int f = 0; f < 2; f++) begin
            bus.frame_end = 1'b1;
            tick();
            bus.frame_end = 1'b0;
            check("flush_wait", bus.writedata, 32'h0);
            tick();
            check("flush_idle_word", bus.writedata, flush_w(f == 0));
            tick();
            check("flush_fgap", bus.writedata, 32'h0);
            check("flush_buf_hold", 32'(bus.back_buf), (f == 0) ? 32'd1 : 32'd0);
`ifdef CMD_WORD_COUNT_EN
            check("words_last_frame", 32'(bus.words_last_frame), (f == 0) ? 32'd2 : 32'd0);
`endif
            tick();
            check("flush_buf_swap", 32'(bus.back_buf), (f == 0) ? 32'd0 : 32'd1);
            tick();
        end

        // frame_end during the x word of a four-field object.
        r.sub = 6'd5; r.child = 5'd3; r.mask = 4'hF; r.vis = 1'b0; r.flip = 1'b1;
        r.pat = 5'd9; r.x = 10'h155; r.y = 10'h2AA; r.sh = 10'h3FF;
        v4 = make_vec(r, 1'b1);
        set_req(r, 1'b1);
        tick();
        bus.req_valid = 1'b0;
        tick();
        tick();
        check("mid_attr", bus.writedata, v4.w[0]);
        tick();
        tick();
        check("mid_x", bus.writedata, v4.w[1]);
        bus.frame_end = 1'b1;
        tick();
        bus.frame_end = 1'b0;
        check("mid_gap", bus.writedata, 32'h0);
        tick();
        check("mid_y", bus.writedata, v4.w[2]);
        tick();
        tick();
        check("mid_shift", bus.writedata, v4.w[3]);
        tick();
        check("mid_gap2", bus.writedata, 32'h0);
        tick();
        check("mid_idle", bus.writedata, 32'h0);
        tick();
        check("mid_flush", bus.writedata, flush_w(1'b1));
        tick();
        tick();
        check("mid_buf", 32'(bus.back_buf), 32'd0);
        tick();

        // Two strobes before the flush is serviced.
        bus.frame_end = 1'b1;
        tick();
        tick();
        bus.frame_end = 1'b0;
        check("ovr_flush", bus.writedata, flush_w(1'b0));
        nz = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (bus.writedata != 32'h0) nz++;
        end
        check("ovr_single_flush", 32'(nz), 32'd0);
        check("ovr_sticky", 32'(bus.flush_overrun), 32'd1);
        check("ovr_buf", 32'(bus.back_buf), 32'd1);

        // Reset in the gap after the attr word, with a second object queued.
        r.mask = 4'hF;
        set_req(r, 1'b1);
        tick();
        r.mask = 4'b0011;
        set_req(r, 1'b1);
        tick();
        bus.req_valid = 1'b0;
        tick();
        check("rgap_attr", bus.writedata, v4.w[0]);
        tick();
        reset = 1'b1;
        tick();
        check("rgap_writedata", bus.writedata, 32'h0);
        check("rgap_back_buf", 32'(bus.back_buf), 32'd1);
        check("rgap_overrun", 32'(bus.flush_overrun), 32'd0);
        check("rgap_ready", 32'(bus.req_ready), 32'd1);
        reset = 1'b0;
        nz = 0;
        for (int k = 0; k < 14; k++) begin
            tick();
            if (bus.writedata != 32'h0) nz++;
        end
        check("rgap_discard", 32'(nz), 32'd0);

        // Table of single objects, back buffer is 1.
        for (int i = 0; i < 10; i++) run_vec(tbl[i], i);

        // Fill the FIFO behind a four-field object.
        apply_reset();
        exp_q.delete();
        objn_q.delete();
        obj_left = 0;
        prev_w = 32'h0;
        model_buf = 1'b1;
        mon_en = 1'b1;
        r = rand_req();
        r.mask = 4'hF;
        n_acc = 0;
        saw_low = 1'b0;
        for (int k = 0; k < 30 && !saw_low; k++) begin
            set_req(r, 1'b1);
            if (bus.req_ready) begin
                push_exp(r);
                n_acc++;
                tick();
                r = rand_req();
            end else begin
                saw_low = 1'b1;
            end
        end
        bus.req_valid = 1'b0;
        check("fill_ready_drop", 32'(saw_low), 32'd1);
        check("fill_accepts", 32'(n_acc), 32'd9);
        drain(400);
        check("fill_ready_back", 32'(bus.req_ready), 32'd1);

        // Random traffic with spaced frame strobes.
        flush_seen = 0;
        pulses = 0;
        last_fe = -100;
        for (int c = 0; c < 700; c++) begin
            r = rand_req();
            set_req(r, 1'($urandom_range(0, 1)));
            bus.frame_end = 1'b0;
            if (c - last_fe >= 30 && $urandom_range(0, 9) == 0) begin
                bus.frame_end = 1'b1;
                pulses++;
                last_fe = c;
            end
            if (bus.req_valid && bus.req_ready) push_exp(r);
            tick();
        end
        bus.req_valid = 1'b0;
        bus.frame_end = 1'b0;
        drain(600);
        check("rand_flush_count", 32'(flush_seen), 32'(pulses));
        check("rand_overrun", 32'(bus.flush_overrun), 32'd0);
        mon_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
